// File: rtl/stream_bytepack_if.sv
// Handshake and control bundle for stream_bytepack: sample input stream, byte output stream,
// abort and group mask. "master" is the environment's view, "slave" is the packer's view.
interface stream_bytepack_if #(
  parameter int SDW = 32
) ();
  localparam int NG = SDW / 8;

  logic            ctl_clr;
  logic [NG-1:0]   cfg_grp;
  logic            sti_tready;
  logic            sti_tvalid;
  logic            sti_tlast;
  logic [SDW-1:0]  sti_tdata;
  logic            sto_tready;
  logic            sto_tvalid;
  logic            sto_tlast;
  logic [7:0]      sto_tdata;

  modport master (
    output ctl_clr, cfg_grp, sti_tvalid, sti_tlast, sti_tdata, sto_tready,
    input  sti_tready, sto_tvalid, sto_tlast, sto_tdata
  );

  modport slave (
    input  ctl_clr, cfg_grp, sti_tvalid, sti_tlast, sti_tdata, sto_tready,
    output sti_tready, sto_tvalid, sto_tlast, sto_tdata
  );
endinterface

// File: rtl/stream_bytepack.sv
// Splits each SDW-bit sample into its enabled byte groups and emits them one per transfer,
// lowest group first, with the sample's last marker on the final enabled byte.
module stream_bytepack #(
  parameter int SDW = 32
) (
  input  logic               clk,
  input  logic               rst,
  stream_bytepack_if.slave   bus
);
  localparam int NG = SDW / 8;
  localparam int IW = (NG > 1) ? $clog2(NG) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  function automatic logic [IW-1:0] lowestIdx(input logic [NG-1:0] m);
    lowestIdx = '0;
    for (int g = NG - 1; g >= 0; g--) begin
      if (m[g]) lowestIdx = IW'(g);
    end
  endfunction

  // True when at most one bit of the mask is set.
  function automatic logic atMostOne(input logic [NG-1:0] m);
    atMostOne = ((m & (m - NG'(1))) == '0);
  endfunction

  function automatic logic [7:0] pickByte(input logic [SDW-1:0] d, input logic [IW-1:0] idx);
    pickByte = '0;
    for (int g = 0; g < NG; g++) begin
      if (IW'(g) == idx) pickByte = d[8*g +: 8];
    end
  endfunction

  logic [0:0]     r_state;
  logic [SDW-1:0] r_data;
  logic [NG-1:0]  r_mask;
  logic           r_last;
  logic [IW-1:0]  r_idx;
  logic [7:0]     r_oData;
  logic           r_oLast;

  logic [NG-1:0]  w_above;
  logic           w_hasNext;
  logic [IW-1:0]  w_nextIdx;
  logic           w_nextIsLast;
  logic [IW-1:0]  w_firstIdx;
  logic           w_firstIsLast;
  logic           w_stiReady;
  logic           w_inXfer;
  logic           w_outXfer;

  // Enabled groups strictly above the byte currently presented.
  always_comb begin
    w_above = '0;
    for (int g = 0; g < NG; g++) begin
      w_above[g] = r_mask[g] && (g > int'(r_idx));
    end
  end

  assign w_hasNext     = |w_above;
  assign w_nextIdx     = lowestIdx(w_above);
  assign w_nextIsLast  = atMostOne(w_above);
  assign w_firstIdx    = lowestIdx(bus.cfg_grp);
  assign w_firstIsLast = atMostOne(bus.cfg_grp);

  assign w_stiReady = ~bus.ctl_clr & ((r_state == IDLE) | (bus.sto_tready & ~w_hasNext));
  assign w_inXfer   = bus.sti_tvalid & w_stiReady;
  assign w_outXfer  = (r_state == SEND) & bus.sto_tready;

  assign bus.sti_tready = w_stiReady;
  assign bus.sto_tvalid = (r_state == SEND);
  assign bus.sto_tlast  = r_oLast;
  assign bus.sto_tdata  = r_oData;

  // Abort beats a new sample, which beats advancing within the held sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_mask  <= '0;
      r_last  <= 1'b0;
      r_idx   <= '0;
      r_oData <= '0;
      r_oLast <= 1'b0;
    end else if (bus.ctl_clr) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_mask  <= '0;
      r_last  <= 1'b0;
      r_idx   <= '0;
      r_oData <= '0;
      r_oLast <= 1'b0;
    end else if (w_inXfer) begin
      r_data <= bus.sti_tdata;
      r_mask <= bus.cfg_grp;
      r_last <= bus.sti_tlast;
      if (|bus.cfg_grp) begin
        r_state <= SEND;
        r_idx   <= w_firstIdx;
        r_oData <= pickByte(bus.sti_tdata, w_firstIdx);
        r_oLast <= bus.sti_tlast & w_firstIsLast;
      end else begin
        r_state <= IDLE;
        r_idx   <= '0;
        r_oData <= '0;
        r_oLast <= 1'b0;
      end
    end else if (w_outXfer) begin
      if (w_hasNext) begin
        r_idx   <= w_nextIdx;
        r_oData <= pickByte(r_data, w_nextIdx);
        r_oLast <= r_last & w_nextIsLast;
      end else begin
        r_state <= IDLE;
        r_oData <= '0;
        r_oLast <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_bytepack.sv
// Directed bench for stream_bytepack (SDW=32): drives at the falling edge, checks #1 later,
// so handshakes complete at the following rising edge.
module tb_stream_bytepack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] expQ[$];

  always #5 clk = ~clk;

  stream_bytepack_if #(.SDW(32)) bus ();
  stream_bytepack #(.SDW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic driveIdle();
    bus.ctl_clr    = 1'b0;
    bus.sti_tvalid = 1'b0;
    bus.sti_tlast  = 1'b0;
    bus.sti_tdata  = '0;
    bus.sto_tready = 1'b1;
  endtask

  task automatic test_reset();
    driveIdle();
    bus.cfg_grp = 4'hF;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({bus.sto_tvalid, bus.sto_tlast, bus.sto_tdata} !== 10'h000) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got %h want 000", {bus.sto_tvalid, bus.sto_tlast, bus.sto_tdata});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.sti_tready !== 1'b1 || bus.sto_tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release ready/valid got %b%b want 10", bus.sti_tready, bus.sto_tvalid);
    end
  endtask

  task automatic test_basic();
    logic [7:0] expBytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(negedge clk);
    bus.cfg_grp = 4'hF; bus.sti_tdata = 32'h44332211; bus.sti_tlast = 1'b1; bus.sti_tvalid = 1'b1;
    #1;
    vectors++;
    if (bus.sti_tready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL basic_accept_ready got %b want 1", bus.sti_tready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.sti_tvalid = 1'b0;
      #1;
      vectors++;
      if ({bus.sto_tvalid, bus.sto_tdata, bus.sto_tlast, bus.sti_tready} !== {1'b1, expBytes[i], i == 3, i == 3}) begin
        miscompares++;
        $display("[TB] FAIL basic_byte%0d valid/data/last/ready got %b/%h/%b/%b want 1/%h/%b/%b", i,
                 bus.sto_tvalid, bus.sto_tdata, bus.sto_tlast, bus.sti_tready, expBytes[i], i == 3, i == 3);
      end
    end
    @(negedge clk);
    #1;
    vectors++;
    if (bus.sto_tvalid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL basic_idle_after valid got %b want 0", bus.sto_tvalid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] expBytes [4] = '{8'hDD, 8'hBB, 8'h44, 8'h22};
    logic       expLast  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       expReady [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    bus.cfg_grp = 4'b0101; bus.sti_tdata = 32'hAABBCCDD; bus.sti_tlast = 1'b0; bus.sti_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.sti_tdata = 32'h11223344; bus.sti_tlast = 1'b1;
      end
      if (i == 2) begin
        bus.sti_tvalid = 1'b0; bus.cfg_grp = 4'hF;
      end
      #1;
      vectors++;
      if ({bus.sto_tvalid, bus.sto_tdata, bus.sto_tlast} !== {1'b1, expBytes[i], expLast[i]}) begin
        miscompares++;
        $display("[TB] FAIL b2b_byte%0d valid/data/last got %b/%h/%b want 1/%h/%b", i,
                 bus.sto_tvalid, bus.sto_tdata, bus.sto_tlast, expBytes[i], expLast[i]);
      end
      if (i < 2) begin
        vectors++;
        if (bus.sti_tready !== expReady[i]) begin
          miscompares++;
          $display("[TB] FAIL b2b_ready%0d got %b want %b", i, bus.sti_tready, expReady[i]);
        end
      end
    end
    @(negedge clk);
    #1;
    vectors++;
    if (bus.sto_tvalid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL b2b_idle_after valid got %b want 0", bus.sto_tvalid);
    end
  endtask

  task automatic test_stall();
    int         sent = 0;
    int         got = 0;
    logic       stalled = 1'b0;
    logic [7:0] heldData = '0;
    logic [7:0] want;
    bus.cfg_grp = 4'b0001;
    bus.sti_tlast = 1'b0;
    expQ.delete();
    for (int cyc = 0; cyc < 300 && got < 6; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        vectors++;
        if (bus.sto_tvalid !== 1'b1 || bus.sto_tdata !== heldData) begin
          miscompares++;
          $display("[TB] FAIL stall_hold valid/data got %b/%h want 1/%h", bus.sto_tvalid, bus.sto_tdata, heldData);
        end
      end
      bus.sto_tready = 1'($urandom_range(0, 1));
      bus.sti_tvalid = (sent < 6);
      bus.sti_tdata  = {8'hEE, 8'hDD, 8'hCC, 8'(8'h50 + sent)};
      #1;
      if (bus.sto_tvalid && bus.sto_tready) begin
        want = (expQ.size() > 0) ? expQ.pop_front() : 8'hXX;
        vectors++;
        if (bus.sto_tdata !== want || bus.sto_tlast !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL stall_byte%0d data/last got %h/%b want %h/0", got, bus.sto_tdata, bus.sto_tlast, want);
        end
        got++;
      end
      if (bus.sti_tvalid && bus.sti_tready) begin
        expQ.push_back(8'(8'h50 + sent));
        sent++;
      end
      stalled  = bus.sto_tvalid && !bus.sto_tready;
      heldData = bus.sto_tdata;
    end
    vectors++;
    if (got != 6) begin
      miscompares++; $display("[TB] FAIL stall_count bytes got %0d want 6", got);
    end
    @(negedge clk);
    driveIdle();
  endtask

  task automatic test_zero_mask();
    bus.cfg_grp = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.sti_tvalid = 1'b1; bus.sti_tlast = 1'b1; bus.sti_tdata = 32'hCAFE0000 + i;
      #1;
      vectors++;
      if (bus.sti_tready !== 1'b1 || bus.sto_tvalid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL zero_mask%0d ready/valid got %b%b want 10", i, bus.sti_tready, bus.sto_tvalid);
      end
    end
    @(negedge clk);
    bus.sti_tvalid = 1'b0;
    #1;
    vectors++;
    if (bus.sto_tvalid !== 1'b0 || bus.sto_tlast !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL zero_mask_after valid/last got %b%b want 00", bus.sto_tvalid, bus.sto_tlast);
    end
  endtask

  task automatic test_clear();
    @(negedge clk);
    bus.cfg_grp = 4'hF; bus.sti_tdata = 32'h44332211; bus.sti_tlast = 1'b1; bus.sti_tvalid = 1'b1;
    @(negedge clk);
    bus.sti_tvalid = 1'b0;
    @(negedge clk);
    bus.ctl_clr = 1'b1; bus.sti_tvalid = 1'b1; bus.sti_tdata = 32'h88776655;
    #1;
    vectors++;
    if (bus.sti_tready !== 1'b0 || bus.sto_tdata !== 8'h22) begin
      miscompares++;
      $display("[TB] FAIL clear_pulse ready/data got %b/%h want 0/22", bus.sti_tready, bus.sto_tdata);
    end
    @(negedge clk);
    bus.ctl_clr = 1'b0;
    #1;
    vectors++;
    if (bus.sto_tvalid !== 1'b0 || bus.sti_tready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL clear_after valid/ready got %b%b want 01", bus.sto_tvalid, bus.sti_tready);
    end
    @(negedge clk);
    bus.sti_tvalid = 1'b0;
    #1;
    vectors++;
    if ({bus.sto_tvalid, bus.sto_tdata, bus.sto_tlast} !== {1'b1, 8'h55, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL clear_next_sample valid/data/last got %b/%h/%b want 1/55/0",
               bus.sto_tvalid, bus.sto_tdata, bus.sto_tlast);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_rst_mid();
    logic [7:0] expBytes [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    @(negedge clk);
    bus.cfg_grp = 4'hF; bus.sti_tdata = 32'h44332211; bus.sti_tlast = 1'b1; bus.sti_tvalid = 1'b1;
    @(negedge clk);
    bus.sti_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (bus.sto_tdata !== 8'h33) begin
      miscompares++; $display("[TB] FAIL rst_mid_third data got %h want 33", bus.sto_tdata);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.sto_tvalid, bus.sto_tlast, bus.sto_tdata} !== 10'h000) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_async got %h want 000", {bus.sto_tvalid, bus.sto_tlast, bus.sto_tdata});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.sti_tready !== 1'b1 || bus.sto_tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_release ready/valid got %b%b want 10", bus.sti_tready, bus.sto_tvalid);
    end
    @(negedge clk);
    bus.sti_tdata = 32'hDDCCBBAA; bus.sti_tlast = 1'b1; bus.sti_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.sti_tvalid = 1'b0;
      #1;
      vectors++;
      if ({bus.sto_tvalid, bus.sto_tdata, bus.sto_tlast} !== {1'b1, expBytes[i], i == 3}) begin
        miscompares++;
        $display("[TB] FAIL rst_mid_resend%0d valid/data/last got %b/%h/%b want 1/%h/%b", i,
                 bus.sto_tvalid, bus.sto_tdata, bus.sto_tlast, expBytes[i], i == 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_zero_mask();
    test_clear();
    test_rst_mid();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stream_bytepack.md
STREAM_BYTEPACK -- requirements
Module: stream_bytepack

Interface
REQ-001 Parameter SDW, default 32: sample data width in bits; SHALL be a multiple of 8, range 8..64.
REQ-002 Derived constant NG = SDW/8: number of byte groups per sample.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ctl_clr  input  1  synchronous abort; discards the sample being emitted.
REQ-006 cfg_grp  input  NG  group enable mask; bit g enables byte sti_tdata[8g+7:8g].
REQ-007 sti_tready  output  1  input stream ready.
REQ-008 sti_tvalid  input  1  input stream valid.
REQ-009 sti_tlast  input  1  input stream last marker; comes from the sample counter's sto_tlast.
REQ-010 sti_tdata  input  SDW  input sample.
REQ-011 sto_tready  input  1  output byte stream ready.
REQ-012 sto_tvalid  output  1  output byte valid, registered.
REQ-013 sto_tlast  output  1  output last marker, registered.
REQ-014 sto_tdata  output  8  output byte, registered.

Function
REQ-015 Handshakes: a transfer SHALL occur on a cycle where tvalid=1 and tready=1 on that port; sto_tvalid, once asserted, SHALL NOT drop and sto_tdata/sto_tlast SHALL NOT change until a transfer occurs or ctl_clr/rst is asserted.
REQ-016 On sample accept, the block SHALL capture sti_tdata, sti_tlast and cfg_grp into internal registers; later cfg_grp changes SHALL NOT affect that sample.
REQ-017 States: IDLE has no sample held, sto_tvalid=0. SEND has a sample held, sto_tvalid=1.
REQ-018 IDLE->SEND on input transfer with a captured mask that is nonzero.
REQ-019 SEND->IDLE on transfer of the last enabled byte, unless a new input transfer occurs in the same cycle; in that case SEND SHALL be kept with the new sample.
REQ-020 Emission order: enabled groups SHALL be emitted in ascending index, group 0 first; disabled groups SHALL be skipped with no idle cycles between bytes.
REQ-021 Latency: the first byte of a sample SHALL be presented on sto_tdata in the cycle after the input transfer.
REQ-022 sti_tready SHALL be (state==IDLE) OR (sto_tready AND the current byte is the last enabled byte); this is a combinational path from sto_tready.
REQ-023 With one enabled group and sto_tready held at 1, throughput SHALL be one sample per cycle; with k enabled groups it SHALL be one sample per k cycles.
REQ-024 sto_tlast SHALL be 1 only on the last enabled byte of a sample captured with sti_tlast=1; otherwise it SHALL be 0.
REQ-025 Zero mask: a sample accepted with captured mask 0 SHALL be consumed and produce no output bytes; its tlast SHALL be dropped; state SHALL go to or stay in IDLE.
REQ-026 ctl_clr=1: next state SHALL be IDLE, sto_tvalid=0, and the held sample SHALL be discarded; sti_tready SHALL be forced to 0 in that cycle, so no sample is accepted.
REQ-027 ctl_clr has priority over any simultaneous input or output transfer; an output transfer in that cycle still counts as completed for the byte presented.
REQ-028 The byte index SHALL be held as a one-hot or binary pointer over NG groups; next index = lowest enabled group above the current one; "last" = no enabled group above the current one.

Reset
REQ-029 While rst=1: state=IDLE; sto_tvalid=0, sto_tlast=0, sto_tdata=8'h00; held sample, mask and index SHALL clear to 0.
REQ-030 After rst deassertion, sti_tready SHALL be 1 in IDLE; no byte SHALL appear until a sample is accepted.
REQ-031 rst asserted mid-sample SHALL drop the remaining bytes immediately (asynchronously) with no partial tlast.

Verification
REQ-032 SDW=32, cfg_grp=4'hF, sample 32'h44332211, tlast=1, sto_tready=1 -> bytes 11,22,33,44 on 4 consecutive cycles starting at accept+1; tlast only on 44; sti_tready=1 only on the 44 cycle.
REQ-033 cfg_grp=4'b0101, back-to-back samples AABBCCDD and 11223344 -> output DD,BB,44,22 with no gaps; cfg_grp changed to 4'hF mid-sample has no effect on the held sample.
REQ-034 cfg_grp=4'b0001, sto_tready random 50% -> every byte is stable while stalled; one byte per sample, in order; no loss or duplication against a scoreboard.
REQ-035 cfg_grp=0, 3 samples with last=1 -> all accepted one per cycle; sto_tvalid stays 0.
REQ-036 ctl_clr pulsed on the 2nd byte of a 4-byte sample -> sto_tvalid=0 next cycle; sti_tready=0 during the pulse; the next sample is emitted from group 0.
REQ-037 rst pulsed on the 3rd byte -> sto_tvalid/sto_tlast/sto_tdata=0 immediately; after release, sti_tready=1 and the next sample is emitted intact.
